// File: rtl/multdiv_pkg.sv
// Shared constants, ALU opcodes and FSM state encoding for the multiply/divide sequencer.
package multdiv_pkg;
  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 6;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL_ITER = 3'd1,
    S_DIV_NEGA = 3'd2,
    S_DIV_NEGB = 3'd3,
    S_DIV_ITER = 3'd4,
    S_DIV_FIX  = 3'd5,
    S_DONE     = 3'd6
  } md_state_e;
endpackage

// File: rtl/multdiv_iter_counter.sv
// Iteration counter for the multiply/divide loops: counts 0..WIDTH-1, flags the last step.
module multdiv_iter_counter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic clock,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign last = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// Multiply (radix-2 Booth) / divide (restoring) sequencer driving an external ADD/SUB ALU.
// Divide path is built only when MULTDIV_DIV_EN is defined; otherwise DIV reports an exception.
//
// state      | meaning
// S_IDLE     | waiting for ctrl_MULT / ctrl_DIV
// S_MUL_ITER | one Booth add/sub + arithmetic shift per cycle, 32 cycles
// S_DIV_NEGA | |A| via ALU 0-A
// S_DIV_NEGB | |B| via ALU 0-B, remainder cleared
// S_DIV_ITER | one restoring shift/subtract per cycle, 32 cycles
// S_DIV_FIX  | negate quotient when operand signs differ
// S_DONE     | result valid, RDY pulse; a new start may be accepted here
module multdiv_seq_ctrl
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  md_state_e        state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] qr_q, qr_d;
  logic [WIDTH-1:0] phi_q, phi_d;
  logic             q1_q, q1_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             cnt_clr, cnt_en, cnt_last;
  logic [WIDTH-1:0] mul_phi_nxt, mul_q_nxt;

`ifdef MULTDIV_DIV_EN
  logic [WIDTH-1:0] b_q, b_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] r_sh, q_sh;

  assign r_sh = {phi_q[WIDTH-2:0], qr_q[WIDTH-1]};
  assign q_sh = {qr_q[WIDTH-2:0], 1'b0};
`endif

  // Arithmetic right shift of {alu_result, Q, q_1}
  assign mul_phi_nxt = {alu_result[WIDTH-1], alu_result[WIDTH-1:1]};
  assign mul_q_nxt   = {alu_result[0], qr_q[WIDTH-1:1]};

  multdiv_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .clock  (clock),
    .resetn (resetn),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .last   (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    qr_d       = qr_q;
    phi_d      = phi_q;
    q1_d       = q1_q;
    result_d   = result_q;
    exc_d      = exc_q;
    rdy_d      = 1'b0;
`ifdef MULTDIV_DIV_EN
    b_d        = b_q;
    sign_d     = sign_q;
`endif
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = ALU_ADD;

    case (state_q)
      S_MUL_ITER: begin
        cnt_en = 1'b1;
        alu_a  = phi_q;
        case ({qr_q[0], q1_q})
          2'b01:   alu_b = m_q;
          2'b10: begin
            alu_b      = m_q;
            alu_opcode = ALU_SUB;
          end
          default: alu_b = '0;
        endcase
        phi_d = mul_phi_nxt;
        qr_d  = mul_q_nxt;
        q1_d  = qr_q[0];
        if (cnt_last) begin
          state_d  = S_DONE;
          result_d = mul_q_nxt;
          exc_d    = (mul_phi_nxt != {WIDTH{mul_q_nxt[WIDTH-1]}});
          rdy_d    = 1'b1;
        end
      end
`ifdef MULTDIV_DIV_EN
      S_DIV_NEGA: begin
        alu_b      = m_q;
        alu_opcode = ALU_SUB;
        qr_d       = m_q[WIDTH-1] ? alu_result : m_q;
        state_d    = S_DIV_NEGB;
      end
      S_DIV_NEGB: begin
        alu_b      = b_q;
        alu_opcode = ALU_SUB;
        b_d        = b_q[WIDTH-1] ? alu_result : b_q;
        phi_d      = '0;
        cnt_clr    = 1'b1;
        state_d    = S_DIV_ITER;
      end
      S_DIV_ITER: begin
        cnt_en     = 1'b1;
        alu_a      = r_sh;
        alu_b      = b_q;
        alu_opcode = ALU_SUB;
        // Magnitudes are unsigned, so |B| = 2^31 still compares correctly
        if (r_sh >= b_q) begin
          phi_d = alu_result;
          qr_d  = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          phi_d = r_sh;
          qr_d  = q_sh;
        end
        if (cnt_last) state_d = S_DIV_FIX;
      end
      S_DIV_FIX: begin
        if (sign_q) begin
          alu_b      = qr_q;
          alu_opcode = ALU_SUB;
          result_d   = alu_result;
        end else begin
          result_d   = qr_q;
        end
        exc_d   = 1'b0;
        rdy_d   = 1'b1;
        state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_IDLE || state_q == S_DONE) begin
      if (ctrl_MULT) begin
        state_d = S_MUL_ITER;
        m_d     = data_operandA;
        qr_d    = data_operandB;
        phi_d   = '0;
        q1_d    = 1'b0;
        cnt_clr = 1'b1;
      end else if (ctrl_DIV) begin
`ifdef MULTDIV_DIV_EN
        if (data_operandB == '0) begin
          state_d  = S_DONE;
          result_d = '0;
          exc_d    = 1'b1;
          rdy_d    = 1'b1;
        end else begin
          state_d = S_DIV_NEGA;
          m_d     = data_operandA;
          b_d     = data_operandB;
          sign_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        end
`else
        state_d  = S_DONE;
        result_d = '0;
        exc_d    = 1'b1;
        rdy_d    = 1'b1;
`endif
      end
    end
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      m_q      <= '0;
      qr_q     <= '0;
      phi_q    <= '0;
      q1_q     <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MULTDIV_DIV_EN
      b_q      <= '0;
      sign_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      qr_q     <= qr_d;
      phi_q    <= phi_d;
      q1_q     <= q1_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
`ifdef MULTDIV_DIV_EN
      b_q      <= b_d;
      sign_q   <= sign_d;
`endif
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// Randomized bench for multdiv_seq_ctrl with a behavioural ADD/SUB ALU and an arithmetic reference model.
module tb_multdiv_seq_ctrl;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] alu_a, alu_b, alu_result, data_result;
  logic [4:0]  alu_opcode;
  logic        data_exception, data_resultRDY, busy;

  int n_chk = 0;
  int n_bad = 0;

  multdiv_seq_ctrl dut (
    .clock          (clock),
    .resetn         (resetn),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_opcode     (alu_opcode),
    .alu_result     (alu_result),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  assign alu_result = (alu_opcode == 5'b00001) ? alu_a - alu_b : alu_a + alu_b;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected result, exception and RDY cycle (start = cycle 0) from plain signed arithmetic.
  function automatic void model(input bit mul, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output bit e, output int lat);
    int          sa, sb, lo;
    longint      la, lb, prod, lo64;
    logic [63:0] pv;
    sa = a;
    sb = b;
    la = sa;
    lb = sb;
    if (mul) begin
      prod = la * lb;
      pv   = prod;
      r    = pv[31:0];
      lo   = pv[31:0];
      lo64 = lo;
      e    = (prod != lo64);
      lat  = 33;
    end else begin
      r   = '0;
      e   = 1'b1;
      lat = 1;
`ifdef MULTDIV_DIV_EN
      if (b != 0) begin
        prod = la / lb;
        pv   = prod;
        r    = pv[31:0];
        e    = 1'b0;
        lat  = 36;
      end
`endif
    end
  endfunction

  // Issue one op at the current negedge; returns at the negedge of the RDY cycle.
  task automatic do_op(input string tag, input bit mul, input bit both,
                       input logic [31:0] a, input logic [31:0] b, input int inject);
    logic [31:0] er;
    bit          ee;
    int          elat;
    int          lat;
    model(mul || both, a, b, er, ee, elat);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = mul || both;
    ctrl_DIV      = !mul || both;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    chk({tag, ":busy1"}, busy, 1);
    lat = 1;
    while (!data_resultRDY && lat < 60) begin
      @(negedge clock);
      lat++;
      ctrl_MULT = (inject != 0 && lat == inject);
    end
    ctrl_MULT = 1'b0;
    chk({tag, ":lat"}, lat, elat);
    chk({tag, ":res"}, data_result, er);
    chk({tag, ":exc"}, data_exception, ee);
    chk({tag, ":busy_rdy"}, busy, 1);
  endtask

  task automatic idle(input int n);
    @(negedge clock);
    chk("rdy_pulse", data_resultRDY, 0);
    chk("busy_idle", busy, 0);
    repeat (n - 1) @(negedge clock);
  endtask

  initial begin
    logic [31:0] a, b;
    bit          mul, seen_rdy;
    int          gap;

    repeat (2) @(negedge clock);
    chk("rst_res", data_result, 0);
    chk("rst_rdy", data_resultRDY, 0);
    chk("rst_busy", busy, 0);
    chk("rst_exc", data_exception, 0);
    chk("rst_alu", {alu_a, alu_b}, 0);
    chk("rst_op", alu_opcode, 0);
    resetn = 1'b1;
    @(negedge clock);

    do_op("m7x-3", 1, 0, 32'd7, -32'sd3, 0);
    chk("m7x-3:val", data_result, 32'hFFFF_FFEB);
    idle(1);
    do_op("movf", 1, 0, 32'h4000_0000, 32'd4, 0);
    do_op("mneg", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    idle(1);
    do_op("d-17/5", 0, 0, -32'sd17, 32'd5, 0);
    do_op("d100/-7", 0, 0, 32'd100, -32'sd7, 0);
    do_op("d5/0", 0, 0, 32'd5, 32'd0, 0);
    do_op("dmin/-1", 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    idle(1);
    do_op("dinj", 0, 0, 32'd1000, 32'd7, 10);
    do_op("both", 1, 1, 32'd123, -32'sd45, 0);
    idle(2);

    data_operandA = 32'h0001_2345;
    data_operandB = 32'h0000_0321;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (14) @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("arst_res", data_result, 0);
    chk("arst_rdy", data_resultRDY, 0);
    chk("arst_busy", busy, 0);
    chk("arst_alu", {alu_a, alu_b}, 0);
    seen_rdy = 1'b0;
    repeat (3) begin
      @(negedge clock);
      seen_rdy |= data_resultRDY;
    end
    resetn = 1'b1;
    repeat (40) begin
      @(negedge clock);
      seen_rdy |= data_resultRDY;
    end
    chk("arst_nordy", seen_rdy, 0);
    do_op("m_after_rst", 1, 0, 32'h0001_2345, 32'h0000_0321, 0);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      mul = $urandom_range(0, 1);
      a   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000;
      if (mul && a == 32'h8000_0000) a = 32'd1;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(0, 40)) - 32'd20;
        2:       b = 32'd0;
        default: b = 32'($urandom_range(0, 2000000)) - 32'd1000000;
      endcase
      do_op(mul ? "rmul" : "rdiv", mul, 0, a, b, 0);
      gap = $urandom_range(0, 2);
      if (gap != 0) idle(gap);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
